iir_biquad_sequencer: RTL and testbench

- Time-multiplexed controller for the fixed-point IIR biquad section. One signed multiplier is shared across the four coefficient products of each sample.
- Sample I/O uses valid/ready handshakes. The host writes coefficients into a shadow bank; the active bank is loaded from the shadow only at sample boundaries.
- Sits between the sample source and downstream stages, replacing the fully parallel section where multiplier area matters.

---
 rtl/iir_pkg.sv | 24 ++
 rtl/iir_shared_mult.sv | 16 +
 rtl/iir_biquad_sequencer.sv | 169 ++++++++++++++++
 tb/tb_iir_biquad_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// Shared types and constants for the time-multiplexed IIR biquad sequencer.
package iir_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_M1   = 3'd1,
        ST_M2   = 3'd2,
        ST_M3   = 3'd3,
        ST_M4   = 3'd4,
        ST_OUT  = 3'd5
    } iir_state_t;

    localparam logic [1:0] IDX_G1 = 2'd0;
    localparam logic [1:0] IDX_G2 = 2'd1;
    localparam logic [1:0] IDX_G3 = 2'd2;
    localparam logic [1:0] IDX_G4 = 2'd3;

    localparam int CK_DEFAULT      = 11;
    localparam int G1_INIT_DEFAULT = 10;
    localparam int G2_INIT_DEFAULT = -1779;
    localparam int G3_INIT_DEFAULT = -1624;
    localparam int G4_INIT_DEFAULT = 986;

endpackage

// File: rtl/iir_shared_mult.sv
// Signed BIT_NO x BIT_NO multiply, arithmetic shift by CK-1, truncated back to BIT_NO.
module iir_shared_mult #(
    parameter int BIT_NO = 32,
    parameter int CK     = 11
) (
    input  logic signed [BIT_NO-1:0] i_a,
    input  logic signed [BIT_NO-1:0] i_b,
    output logic signed [BIT_NO-1:0] o_p
);

    logic signed [2*BIT_NO-1:0] w_prod;

    assign w_prod = (2*BIT_NO)'(i_a) * (2*BIT_NO)'(i_b);
    assign o_p    = BIT_NO'(w_prod >>> (CK - 1));

endmodule

// File: rtl/iir_biquad_sequencer.sv
// Biquad section computed over four cycles on one shared multiplier, with
// shadow/active coefficient banks swapped only when a sample is accepted.
module iir_biquad_sequencer
    import iir_pkg::*;
#(
    parameter int BIT_NO  = 32,
    parameter int CK      = CK_DEFAULT,
    parameter int G1_INIT = G1_INIT_DEFAULT,
    parameter int G2_INIT = G2_INIT_DEFAULT,
    parameter int G3_INIT = G3_INIT_DEFAULT,
    parameter int G4_INIT = G4_INIT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [BIT_NO-1:0] in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [BIT_NO-1:0] out,
    input  logic                     cfg_we,
    input  logic [1:0]               cfg_addr,
    input  logic signed [BIT_NO-1:0] cfg_wdata,
    input  logic                     state_clr,
    output logic                     busy
);

    localparam logic signed [BIT_NO-1:0] C_INIT [4] = '{
        BIT_NO'(G1_INIT), BIT_NO'(G2_INIT), BIT_NO'(G3_INIT), BIT_NO'(G4_INIT)
    };

    iir_state_t                r_state;
    logic signed [BIT_NO-1:0]  r_sample;
    logic signed [BIT_NO-1:0]  r_acc;
    logic signed [BIT_NO-1:0]  r_d1;
    logic signed [BIT_NO-1:0]  r_d2;
    logic signed [BIT_NO-1:0]  r_out;
    logic                      r_out_valid;
    logic signed [BIT_NO-1:0]  r_shadow [4];
    logic signed [BIT_NO-1:0]  r_active [4];

    logic signed [BIT_NO-1:0]  w_shadow_next [4];
    logic signed [BIT_NO-1:0]  w_mul_a;
    logic signed [BIT_NO-1:0]  w_mul_b;
    logic signed [BIT_NO-1:0]  w_p;
    logic                      w_accept;

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign w_accept  = in_valid && (r_state == ST_IDLE);

    // Shadow bank as it will be after this edge, so an accept sees a same-cycle write.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (cfg_we && (cfg_addr == 2'(i))) begin
                w_shadow_next[i] = cfg_wdata;
            end else begin
                w_shadow_next[i] = r_shadow[i];
            end
        end
    end

    // Shared multiplier operand selection, one product per compute state.
    always_comb begin
        w_mul_a = '0;
        w_mul_b = '0;
        case (r_state)
            ST_M1: begin
                w_mul_a = r_sample;
                w_mul_b = r_active[IDX_G1];
            end
            ST_M2: begin
                w_mul_a = r_d1;
                w_mul_b = r_active[IDX_G2];
            end
            ST_M3: begin
                w_mul_a = r_d2;
                w_mul_b = r_active[IDX_G4];
            end
            ST_M4: begin
                w_mul_a = r_d1;
                w_mul_b = r_active[IDX_G3];
            end
            default: begin
                w_mul_a = '0;
                w_mul_b = '0;
            end
        endcase
    end

    iir_shared_mult #(
        .BIT_NO (BIT_NO),
        .CK     (CK)
    ) u_mult (
        .i_a (w_mul_a),
        .i_b (w_mul_b),
        .o_p (w_p)
    );

    // Host-visible shadow coefficient bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow <= C_INIT;
        end else begin
            r_shadow <= w_shadow_next;
        end
    end

    // Sequencer: datapath registers and the result handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_sample    <= '0;
            r_acc       <= '0;
            r_d1        <= '0;
            r_d2        <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_active    <= C_INIT;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // The clear and the accept share an edge; M2 reads the cleared d1.
                    if (state_clr) begin
                        r_d1 <= '0;
                        r_d2 <= '0;
                    end
                    if (w_accept) begin
                        r_sample <= in;
                        r_active <= w_shadow_next;
                        r_state  <= ST_M1;
                    end
                end
                ST_M1: begin
                    r_acc   <= w_p;
                    r_state <= ST_M2;
                end
                ST_M2: begin
                    r_acc   <= r_acc - w_p;
                    r_state <= ST_M3;
                end
                ST_M3: begin
                    r_acc   <= r_acc - w_p;
                    r_state <= ST_M4;
                end
                ST_M4: begin
                    r_out       <= r_acc + w_p + r_d2;
                    r_d2        <= r_d1;
                    r_d1        <= r_acc;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iir_biquad_sequencer.sv
// Self-checking bench: vector table, directed corner sequences and random samples vs a reference model.
module tb_iir_biquad_sequencer;

    localparam int SH = 10;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] din;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] dout;
    logic               cfg_we;
    logic [1:0]         cfg_addr;
    logic signed [31:0] cfg_wdata;
    logic               state_clr;
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;

    int m_sh [4];
    int m_act [4];
    int m_d1;
    int m_d2;

    typedef struct {
        int x;
        bit clr;
        int exp;
    } vec_t;

    vec_t vecs [6];

    iir_biquad_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (dout),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .state_clr (state_clr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int mul(int a, int b);
        longint p;
        p = longint'(a) * longint'(b);
        return int'(p >>> SH);
    endfunction

    task automatic m_reset();
        m_sh  = '{10, -1779, -1624, 986};
        m_act = m_sh;
        m_d1  = 0;
        m_d2  = 0;
    endtask

    function automatic int m_accept(int x, bit clr);
        int x3;
        int y;
        if (clr) begin
            m_d1 = 0;
            m_d2 = 0;
        end
        m_act = m_sh;
        x3 = x * 0 + mul(x, m_act[0]) - mul(m_d1, m_act[1]) - mul(m_d2, m_act[3]);
        y  = x3 + mul(m_d1, m_act[2]) + m_d2;
        m_d2 = m_d1;
        m_d1 = x3;
        return y;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input int d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
        m_sh[a] = d;
    endtask

    task automatic start_sample(input int x, input bit clr, input bit we, input logic [1:0] a,
                                input int wd, output int exp);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) check("in_ready_timeout", {63'd0, in_ready}, 64'sd1);
        in_valid = 1'b1; din = x; state_clr = clr;
        cfg_we = we; cfg_addr = a; cfg_wdata = wd;
        tick();
        in_valid = 1'b0; state_clr = 1'b0; cfg_we = 1'b0;
        if (we) m_sh[a] = wd;
        exp = m_accept(x, clr);
    endtask

    task automatic wait_result(output int y, output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!out_valid) check("out_valid_timeout", {63'd0, out_valid}, 64'sd1);
        y = dout;
    endtask

    task automatic finish_xfer();
        out_ready = 1'b1;
        tick();
        check("xfer_done_valid", {63'd0, out_valid}, 64'sd0);
        check("xfer_done_ready", {63'd0, in_ready}, 64'sd1);
    endtask

    task automatic run_plain(input string name, input int x, input bit clr, input bit we,
                             input logic [1:0] a, input int wd, input bit use_hard, input int hard);
        int e;
        int y;
        int lat;
        start_sample(x, clr, we, a, wd, e);
        wait_result(y, lat);
        check({name, "_latency"}, lat, 64'sd4);
        check({name, "_model"}, y, e);
        if (use_hard) check({name, "_const"}, y, hard);
        finish_xfer();
    endtask

    initial begin
        int e;
        int y;
        int lat;
        int k;
        int x;
        bit clr;
        int mid;

        vecs[0] = '{x: 1024,  clr: 1'b1, exp: 10};
        vecs[1] = '{x: 0,     clr: 1'b0, exp: 2};
        vecs[2] = '{x: 0,     clr: 1'b0, exp: 4};
        vecs[3] = '{x: 1024,  clr: 1'b1, exp: 10};
        vecs[4] = '{x: -1024, clr: 1'b1, exp: -10};
        vecs[5] = '{x: 0,     clr: 1'b0, exp: -2};

        reset = 1'b1; in_valid = 1'b0; din = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; state_clr = 1'b0;
        m_reset();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_out_valid", {63'd0, out_valid}, 64'sd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'sd1);
        check("rst_busy", {63'd0, busy}, 64'sd0);
        check("rst_out", dout, 64'sd0);

        // Vector table: impulse response with default coefficients.
        for (int i = 0; i < 6; i++) begin
            run_plain("vec", vecs[i].x, vecs[i].clr, 1'b0, 2'd0, 0, 1'b1, vecs[i].exp);
        end

        // Backpressure: result held, new input ignored, exactly one transfer.
        out_ready = 1'b0;
        start_sample(1024, 1'b1, 1'b0, 2'd0, 0, e);
        wait_result(y, lat);
        check("bp_first", y, 64'sd10);
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; din = 555;
            tick();
            check("bp_out_stable", dout, 64'sd10);
            check("bp_out_valid", {63'd0, out_valid}, 64'sd1);
            check("bp_in_ready", {63'd0, in_ready}, 64'sd0);
        end
        in_valid = 1'b0;
        finish_xfer();
        check("bp_busy_after", {63'd0, busy}, 64'sd0);
        run_plain("bp_next", 0, 1'b0, 1'b0, 2'd0, 0, 1'b1, 2);

        // Reset in the middle of M2 aborts the sample and restores coefficients.
        cfg_write(2'd0, 77);
        start_sample(1024, 1'b1, 1'b0, 2'd0, 0, e);
        tick();
        reset = 1'b1;
        #1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'sd0);
        check("midrst_busy", {63'd0, busy}, 64'sd0);
        tick();
        reset = 1'b0;
        tick();
        check("midrst_in_ready", {63'd0, in_ready}, 64'sd1);
        m_reset();
        run_plain("midrst_impulse", 1024, 1'b0, 1'b0, 2'd0, 0, 1'b1, 10);

        // Coefficient write during M3 affects only the next sample.
        start_sample(1024, 1'b1, 1'b0, 2'd0, 0, e);
        tick();
        tick();
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 20;
        tick();
        cfg_we = 1'b0;
        m_sh[0] = 20;
        wait_result(y, lat);
        check("shadow_a", y, 64'sd10);
        check("shadow_a_model", y, e);
        finish_xfer();
        run_plain("shadow_b", 1024, 1'b1, 1'b0, 2'd0, 0, 1'b1, 20);

        // Same-cycle write and accept: the accepted sample sees the new G1.
        run_plain("samecyc", 1024, 1'b1, 1'b1, 2'd0, 0, 1'b1, 0);
        cfg_write(2'd0, 10);

        // state_clr in IDLE clears the delay line; during M2 it is ignored.
        run_plain("clr_imp", 1024, 1'b1, 1'b0, 2'd0, 0, 1'b1, 10);
        state_clr = 1'b1;
        tick();
        state_clr = 1'b0;
        m_d1 = 0;
        m_d2 = 0;
        run_plain("clr_idle", 0, 1'b0, 1'b0, 2'd0, 0, 1'b1, 0);
        run_plain("clr_imp2", 1024, 1'b1, 1'b0, 2'd0, 0, 1'b1, 10);
        start_sample(0, 1'b0, 1'b0, 2'd0, 0, e);
        tick();
        state_clr = 1'b1;
        tick();
        state_clr = 1'b0;
        wait_result(y, lat);
        check("clr_m2_ignored", y, 64'sd2);
        check("clr_m2_latency", lat + 2, 64'sd4);
        finish_xfer();

        // Random samples, coefficient writes and output stalls against the model.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                cfg_write(2'($urandom_range(0, 3)), int'($urandom_range(0, 4095)) - 2048);
            end
            x   = ($urandom_range(0, 1) == 0) ? int'($urandom) : int'($urandom_range(0, 8191)) - 4096;
            clr = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) begin
                start_sample(x, clr, 1'b1, 2'($urandom_range(0, 3)), int'($urandom), e);
            end else begin
                start_sample(x, clr, 1'b0, 2'd0, 0, e);
            end
            mid = 0;
            if ($urandom_range(0, 3) == 0) begin
                cfg_we = 1'b1; cfg_addr = 2'($urandom_range(0, 3)); cfg_wdata = int'($urandom_range(0, 4095)) - 2048;
                tick();
                cfg_we = 1'b0;
                m_sh[cfg_addr] = cfg_wdata;
                mid = 1;
            end
            wait_result(y, lat);
            check("rand_latency", lat + mid, 64'sd4);
            check("rand_out", y, e);
            if (!out_ready) begin
                k = $urandom_range(1, 5);
                for (int j = 0; j < k; j++) begin
                    tick();
                    check("rand_hold", dout, e);
                end
            end
            finish_xfer();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
